eight_data_decompress_unit: RTL

- Decompression counterpart of the eight-word compress/merge tree.
- Accepts one packed 256-bit vector plus its eight 2-bit tags per cycle, splits the variable-length fields back out, and expands each to a full 32-bit word.
- Three-stage, fully pipelined, one block per cycle, no backpressure.
- Sits between the compressed-stream reader and the consumer of uncompressed data.

---
 rtl/eight_data_decompress_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/eight_data_decompress_unit.sv
// eight_data_decompress_unit
//   Splits a packed, MSB-aligned 256-bit compressed vector back into eight
//   32-bit words using the eight 2-bit per-word tags, one block per cycle.
//   Tag -> field length: 0 -> 0 bits (zero word), 1 -> 8, 2 -> 16, 3 -> 32.
//   Word 7 occupies the top bits of dataIn, word 0 the lowest used bits.
//
// Build option:
//   DECOMP_SIGN_EXT_EN  defined   : 8/16-bit fields are sign-extended
//                       undefined : 8/16-bit fields are zero-extended
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   wrtEn        input valid, samples dataIn/tagIn
//   dataIn       packed compressed vector (256 bits)
//   tagIn        tag[i] = tagIn[2i+1:2i]
//   dataOut      word i = dataOut[32i+31:32i], holds while validOut low
//   validOut     dataOut/totalLenOut valid this cycle
//   totalLenOut  bits consumed from dataIn for this block (0..256)
//   blkCnt       blocks emitted, wraps at 16'hFFFF
module eight_data_decompress_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wrtEn,
  input  logic [8*DATA_WIDTH-1:0] dataIn,
  input  logic [8*TAG_WIDTH-1:0]  tagIn,
  output logic [8*DATA_WIDTH-1:0] dataOut,
  output logic                    validOut,
  output logic [8:0]              totalLenOut,
  output logic [15:0]             blkCnt
);

  localparam int unsigned NW = 8;
  localparam int unsigned BW = NW * DATA_WIDTH;

  function automatic logic [LEN_WIDTH-1:0] tag_len(input logic [TAG_WIDTH-1:0] t);
    case (t)
      2'd1:    return LEN_WIDTH'(8);
      2'd2:    return LEN_WIDTH'(16);
      2'd3:    return LEN_WIDTH'(32);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] expand(input logic [DATA_WIDTH-1:0] f,
                                                  input logic [TAG_WIDTH-1:0]  t);
    case (t)
`ifdef DECOMP_SIGN_EXT_EN
      2'd1:    return {{(DATA_WIDTH-8){f[DATA_WIDTH-1]}},  f[DATA_WIDTH-1 -: 8]};
      2'd2:    return {{(DATA_WIDTH-16){f[DATA_WIDTH-1]}}, f[DATA_WIDTH-1 -: 16]};
`else
      2'd1:    return {{(DATA_WIDTH-8){1'b0}},  f[DATA_WIDTH-1 -: 8]};
      2'd2:    return {{(DATA_WIDTH-16){1'b0}}, f[DATA_WIDTH-1 -: 16]};
`endif
      2'd3:    return f;
      default: return '0;
    endcase
  endfunction

  // Input capture registers; the offset/length arithmetic of S1 works from
  // these so that the input pins see no logic, giving the 4-edge latency.
  logic                   r0_v;
  logic [BW-1:0]          r0_data;
  logic [NW*TAG_WIDTH-1:0] r0_tag;

  // S1: offsets and total length
  logic                   r1_v;
  logic [BW-1:0]          r1_data;
  logic [NW*TAG_WIDTH-1:0] r1_tag;
  logic [LEN_WIDTH-1:0]   r1_off [NW];
  logic [8:0]             r1_tot;

  // S2: extracted fields
  logic                   r2_v;
  logic [DATA_WIDTH-1:0]  r2_field [NW];
  logic [NW*TAG_WIDTH-1:0] r2_tag;
  logic [8:0]             r2_tot;

  logic [LEN_WIDTH-1:0]   w_off [NW];
  logic [LEN_WIDTH:0]     w_tot;
  logic [DATA_WIDTH-1:0]  w_field [NW];
  logic [BW-1:0]          w_exp;

  // off[i] accumulates the lengths of all higher-numbered words.
  always_comb begin
    logic [LEN_WIDTH:0] acc;
    w_off = '{default: '0};
    acc   = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      w_off[NW-1-k] = acc[LEN_WIDTH-1:0];
      acc = acc + (LEN_WIDTH+1)'(tag_len(r0_tag[TAG_WIDTH*(NW-1-k) +: TAG_WIDTH]));
    end
    w_tot = acc;
  end

  always_comb begin
    logic [BW-1:0] sh;
    w_field = '{default: '0};
    sh      = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      sh         = r1_data << r1_off[k];
      w_field[k] = sh[BW-1 -: DATA_WIDTH];
    end
  end

  always_comb begin
    w_exp = '0;
    for (int unsigned k = 0; k < NW; k++)
      w_exp[DATA_WIDTH*k +: DATA_WIDTH] = expand(r2_field[k], r2_tag[TAG_WIDTH*k +: TAG_WIDTH]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_v     <= 1'b0;
      r0_data  <= '0;
      r0_tag   <= '0;
      r1_v     <= 1'b0;
      r1_data  <= '0;
      r1_tag   <= '0;
      r1_off   <= '{default: '0};
      r1_tot   <= '0;
      r2_v     <= 1'b0;
      r2_field <= '{default: '0};
      r2_tag   <= '0;
      r2_tot   <= '0;
    end else begin
      r0_v <= wrtEn;
      if (wrtEn) begin
        r0_data <= dataIn;
        r0_tag  <= tagIn;
      end
      r1_v <= r0_v;
      if (r0_v) begin
        r1_data <= r0_data;
        r1_tag  <= r0_tag;
        r1_off  <= w_off;
        r1_tot  <= 9'(w_tot);
      end
      r2_v <= r1_v;
      if (r1_v) begin
        r2_field <= w_field;
        r2_tag   <= r1_tag;
        r2_tot   <= r1_tot;
      end
    end
  end

  // Output stage; blkCnt already includes the block presented on validOut.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut     <= '0;
      totalLenOut <= '0;
      validOut    <= 1'b0;
      blkCnt      <= '0;
    end else begin
      validOut <= r2_v;
      if (r2_v) begin
        dataOut     <= w_exp;
        totalLenOut <= r2_tot;
        blkCnt      <= blkCnt + 16'd1;
      end
    end
  end

endmodule
